// File: rtl/wb_arbiter_2m_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m_pkg
//   Shared definitions for the two-master Wishbone arbiter: grant-state
//   encoding, master index constants, bus field widths, the request bundle
//   used by the grant mux, and small helpers for arbitration and sizing.
//   Kept in a package so later multi-master interconnect blocks can reuse
//   the same encodings.
// ---------------------------------------------------------------------------
package wb_arbiter_2m_pkg;

  // Grant FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Master indices, also the encoding of last_gnt.
  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  // Everything a master presents towards the slave, bundled for the mux.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
  } wb_req_t;

  // Watchdog counter width; never below one bit so a disabled watchdog
  // still elaborates cleanly.
  function automatic int wdog_cnt_w(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

  // Round-robin pick from IDLE: m1 wins when it is the only requester, or
  // when both request and m0 held the previous grant.
  function automatic logic pick_m1(input logic req0, input logic req1,
                                   input logic last_gnt);
    return req1 & (~req0 | (last_gnt == M0_IDX));
  endfunction

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m_if
//   Classic Wishbone point-to-point link.
//   master modport : drives adr/dat_w/sel/we/cyc/stb, receives ack/dat_r
//   slave  modport : receives the request, drives ack/err/dat_r
//   err exists only on the arbiter-to-CPU side (watchdog timeout); the boot
//   ROM has no error line, so the master modport does not read it.
// ---------------------------------------------------------------------------
interface wb_arbiter_2m_if;
  import wb_arbiter_2m_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [SEL_W-1:0] sel;
  logic             we;
  logic             cyc;
  logic             stb;
  logic             ack;
  logic             err;
  logic [DAT_W-1:0] dat_r;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  ack, dat_r
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output ack, err, dat_r
  );

endinterface

// File: rtl/wb_arbiter_2m_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m_watchdog
//   Counts cycles of an active (granted cyc & stb) strobe that the slave has
//   not acknowledged. On the TIMEOUT_CYC-th such cycle it raises expire for
//   that one cycle and restarts. TIMEOUT_CYC = 0 disables it entirely.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : granted master has cyc & stb high this cycle
//   ack        : slave acknowledge this cycle
//   expire     : combinational one-cycle timeout pulse
// ---------------------------------------------------------------------------
module wb_arbiter_2m_watchdog
  import wb_arbiter_2m_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = wdog_cnt_w(TIMEOUT_CYC);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_off;
      assign unused_off = ^{clk, rst_n, active, ack};
      assign expire     = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
      logic [CW-1:0] count;

      // An ack in the same cycle as the last count wins over the timeout.
      assign expire = active & ~ack & (count == LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (!active || ack || expire) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m
//   Two-master, one-slave classic Wishbone arbiter sharing the boot ROM
//   between the instruction bus (m0) and data bus (m1). Round-robin grant
//   decided in IDLE, held for the whole bus cycle (cyc), always followed by
//   one IDLE bubble. A watchdog terminates unacknowledged strobes with err.
// Ports
//   i_wb_clk    : clock, all state on the rising edge
//   i_wb_rst_n  : asynchronous active-low reset
//   m0, m1      : master links (arbiter acts as their slave)
//   s           : slave link to the ROM (arbiter acts as its master)
// Parameters
//   TIMEOUT_CYC : unacknowledged strobe cycles before err; 0 disables
// ---------------------------------------------------------------------------
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  wb_arbiter_2m_if.slave  m0,
  wb_arbiter_2m_if.slave  m1,
  wb_arbiter_2m_if.master s
);

  arb_state_e state;
  logic       last_gnt;

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t req;
  logic    active;
  logic    ack_g;
  logic    expire;

  assign req0 = {m0.adr, m0.dat_w, m0.sel, m0.we, m0.cyc, m0.stb};
  assign req1 = {m1.adr, m1.dat_w, m1.sel, m1.we, m1.cyc, m1.stb};

  // Grant FSM. last_gnt resets to m1 so m0 wins the first contention.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state    <= IDLE;
      last_gnt <= M1_IDX;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0.cyc || m1.cyc) begin
            if (pick_m1(m0.cyc, m1.cyc, last_gnt)) begin
              state    <= GNT1;
              last_gnt <= M1_IDX;
            end else begin
              state    <= GNT0;
              last_gnt <= M0_IDX;
            end
          end
        end
        // Leaving a grant always goes through IDLE, even if the other
        // master is already waiting.
        GNT0:    if (!m0.cyc) state <= IDLE;
        GNT1:    if (!m1.cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request mux: in IDLE the slave sees an all-zero request.
  always_comb begin
    req = '0;
    unique case (state)
      GNT0:    req = req0;
      GNT1:    req = req1;
      default: req = '0;
    endcase
  end

  assign active = req.cyc & req.stb;
  // Acks outside a granted, strobed cycle are dropped.
  assign ack_g  = s.ack & active;

  wb_arbiter_2m_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (i_wb_clk),
    .rst_n  (i_wb_rst_n),
    .active (active),
    .ack    (s.ack),
    .expire (expire)
  );

  assign s.adr   = req.adr;
  assign s.dat_w = req.dat;
  assign s.sel   = req.sel;
  assign s.we    = req.we;
  assign s.cyc   = req.cyc;
  // The expiring strobe is withheld so the slave does not see a request
  // that the master is being told has failed.
  assign s.stb   = active & ~expire;

  assign m0.ack   = (state == GNT0) & ack_g;
  assign m0.err   = (state == GNT0) & expire;
  assign m0.dat_r = s.dat_r;

  assign m1.ack   = (state == GNT1) & ack_g;
  assign m1.err   = (state == GNT1) & expire;
  assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;
  import wb_arbiter_2m_pkg::*;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_2m_if m0 ();
  wb_arbiter_2m_if m1 ();
  wb_arbiter_2m_if s ();
  wb_arbiter_2m_if m0z ();
  wb_arbiter_2m_if m1z ();
  wb_arbiter_2m_if sz ();

  wb_arbiter_2m #(.TIMEOUT_CYC(T)) dut (
    .i_wb_clk (clk), .i_wb_rst_n (rst_n), .m0 (m0), .m1 (m1), .s (s)
  );

  // Second build with the watchdog disabled, fed the same traffic.
  wb_arbiter_2m #(.TIMEOUT_CYC(0)) dut_nowd (
    .i_wb_clk (clk), .i_wb_rst_n (rst_n), .m0 (m0z), .m1 (m1z), .s (sz)
  );

  // Boot ROM model: word n reads as A5A5_nnnn.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hA5A5, a[17:2]};
  endfunction

  assign s.dat_r  = rom_word(s.adr);
  assign s.err    = 1'b0;
  assign sz.dat_r = rom_word(sz.adr);
  assign sz.ack   = s.ack;
  assign sz.err   = 1'b0;
  assign {m0z.adr, m0z.dat_w, m0z.sel, m0z.we, m0z.cyc, m0z.stb} =
         {m0.adr, m0.dat_w, m0.sel, m0.we, m0.cyc, m0.stb};
  assign {m1z.adr, m1z.dat_w, m1z.sel, m1z.we, m1z.cyc, m1z.stb} =
         {m1.adr, m1.dat_w, m1.sel, m1.we, m1.cyc, m1.stb};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus state
  wb_req_t r0 = '0;
  wb_req_t r1 = '0;

  task automatic drive_all();
    {m0.adr, m0.dat_w, m0.sel, m0.we, m0.cyc, m0.stb} = r0;
    {m1.adr, m1.dat_w, m1.sel, m1.we, m1.cyc, m1.stb} = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: -1 nobody holds the bus, else index of the master holding it.
  int   owner = -1;
  logic prev  = 1'b1;   // master that held the bus most recently
  int   waited = 0;     // unacknowledged strobe cycles in current run

  always @(negedge clk) begin
    logic [31:0] a, d;
    logic [3:0]  sl;
    logic        c, st, we, to;
    logic        cy_any[2];
    if (!rst_n) begin
      owner = -1; prev = 1'b1; waited = 0;
    end
    cy_any[0] = m0.cyc;
    cy_any[1] = m1.cyc;
    a = '0; d = '0; sl = '0; c = 1'b0; st = 1'b0; we = 1'b0;
    if (owner == 0) {a, d, sl, we, c, st} = {m0.adr, m0.dat_w, m0.sel, m0.we, m0.cyc, m0.stb};
    if (owner == 1) {a, d, sl, we, c, st} = {m1.adr, m1.dat_w, m1.sel, m1.we, m1.cyc, m1.stb};
    to = (owner >= 0) && c && st && !s.ack && (waited == T - 1);

    chk("s_adr", s.adr, a);
    chk("s_dat", s.dat_w, d);
    chk("s_ctl", {25'd0, s.sel, s.we, s.cyc, s.stb}, {25'd0, sl, we, c, c & st & ~to});
    chk("m_resp", {28'd0, m0.ack, m0.err, m1.ack, m1.err},
        {28'd0, owner == 0 && c && st && s.ack, owner == 0 && to,
                owner == 1 && c && st && s.ack, owner == 1 && to});
    chk("m0_rdat", m0.dat_r, rom_word(a));
    chk("m1_rdat", m1.dat_r, rom_word(a));
    chk("nowd_resp", {29'd0, m0z.err | m1z.err, sz.stb, sz.cyc}, {29'd0, 1'b0, c & st, c});

    if (rst_n) begin
      if (owner < 0) begin
        waited = 0;
        if (cy_any[0] && cy_any[1]) owner = (prev == 1'b1) ? 0 : 1;
        else if (cy_any[0])         owner = 0;
        else if (cy_any[1])         owner = 1;
        if (owner >= 0) prev = owner[0];
      end else begin
        waited = (c && st && !s.ack && !to) ? waited + 1 : 0;
        if (!c) begin
          owner  = -1;
          waited = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic wb_req_t rand_req(input wb_req_t cur, input int start_p,
                                       input int drop_p, input int stb_p);
    wb_req_t r = cur;
    if (!cur.cyc) r.cyc = pct(start_p);
    else if (pct(drop_p)) r.cyc = 1'b0;
    r.stb = pct(stb_p);
    if (pct(30)) begin
      r.adr = {24'd0, 6'($urandom), 2'b00};
      r.dat = $urandom;
      r.sel = 4'($urandom);
      r.we  = 1'($urandom);
    end
    return r;
  endfunction

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    r0 = '0; r1 = '0; s.ack = 1'b0;
    drive_all();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n, input int start_p, input int drop_p,
                            input int stb_p, input int ack_p, input int rst_p);
    for (int i = 0; i < n; i++) begin
      tick();
      r0 = rand_req(r0, start_p, drop_p, stb_p);
      r1 = rand_req(r1, start_p, drop_p, stb_p);
      drive_all();
      s.ack = pct(ack_p);
      rst_n = !pct(rst_p);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int acks0, acks1, nerr, first, nerr_z;
    s.ack = 1'b0;
    drive_all();

    // 1: reset mid-transfer, then re-grant one cycle after request
    do_reset();
    r0 = '{adr: 32'h10, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle(); chk("t1_arb_latency", s.cyc, 0);
    tick(); s.ack = 1'b1;
    settle(); chk("t1_granted", s.cyc, 1);
    tick(); rst_n = 1'b0; #1;
    chk("t1_rst_s_cyc", s.cyc, 0);
    chk("t1_rst_no_ack", m0.ack, 0);
    tick(); s.ack = 1'b0;
    tick(); rst_n = 1'b1;
    settle(); chk("t1_rel_idle", s.cyc, 0);
    tick(); settle(); chk("t1_rel_grant", s.cyc, 1);

    // 2: single read of ROM word 2
    do_reset();
    r0 = '{adr: 32'h8, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle(); chk("t2_idle_first", s.stb, 0);
    tick(); s.ack = 1'b1;
    settle();
    chk("t2_adr", s.adr, 32'h8);
    chk("t2_ack", m0.ack, 1);
    chk("t2_rdat", m0.dat_r, 32'hA5A5_0002);
    tick(); r0.cyc = 1'b0; r0.stb = 1'b0; drive_all(); s.ack = 1'b0;
    settle(); chk("t2_ack_pulse", m0.ack, 0);

    // 3: round robin with one IDLE bubble on hand-over
    do_reset();
    r0 = '{adr: 32'h100, dat: 32'h1, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    r1 = '{adr: 32'h200, dat: 32'h2, sel: 4'h3, we: 1'b1, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle(); chk("t3_bubble0", s.cyc, 0);
    tick(); settle(); chk("t3_gnt0_first", s.adr, 32'h100);
    tick(); r0.cyc = 1'b0; r0.stb = 1'b0; drive_all();
    settle(); chk("t3_m0_drop", s.cyc, 0);
    tick(); settle(); chk("t3_handover_idle", s.adr, 32'h0);
    tick(); settle(); chk("t3_gnt1", s.adr, 32'h200);
    tick(); r1.cyc = 1'b0; r1.stb = 1'b0; drive_all();
    settle();
    tick(); r0.cyc = 1'b1; r0.stb = 1'b1; r1.cyc = 1'b1; r1.stb = 1'b1; drive_all();
    settle(); chk("t3_idle_again", s.cyc, 0);
    tick(); settle(); chk("t3_rr_back_m0", s.adr, 32'h100);

    // 4: m1 holds the bus for three reads while m0 waits
    do_reset();
    r1 = '{adr: 32'h300, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle();
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        r0 = '{adr: 32'h400, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        drive_all();
      end
      s.ack = (i % 2 == 0);
      settle();
      acks0 += int'(m0.ack);
      acks1 += int'(m1.ack);
    end
    chk("t4_m1_acks", acks1, 3);
    chk("t4_m0_starved", acks0, 0);
    tick(); r1.cyc = 1'b0; r1.stb = 1'b0; drive_all(); s.ack = 1'b1;
    settle(); chk("t4_stray_ack", {m0.ack, m1.ack}, 2'b00);
    tick(); settle(); chk("t4_idle_ack_ignored", {m0.ack, m1.ack}, 2'b00);
    tick(); settle();
    chk("t4_m0_granted", s.adr, 32'h400);
    chk("t4_m0_ack", m0.ack, 1);
    s.ack = 1'b0;

    // 5: slave never acks -> err every 16th strobe cycle
    do_reset();
    r0 = '{adr: 32'h20, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle();
    nerr = 0; first = 0; nerr_z = 0;
    for (int k = 1; k <= 50; k++) begin
      tick(); settle();
      nerr_z += int'(m0z.err);
      if (m0.err) begin
        nerr++;
        if (first == 0) first = k;
        chk("t5_stb_low_on_err", s.stb, 0);
      end
    end
    chk("t5_err_count", nerr, 3);
    chk("t5_first_err", first, 16);
    chk("t5_nowd_err", nerr_z, 0);

    // 6: ack coincident with the 16th cycle wins; disabled watchdog stays quiet
    do_reset();
    r0 = '{adr: 32'h24, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
    drive_all();
    settle();
    for (int k = 1; k <= 16; k++) begin
      tick(); s.ack = (k == 16); settle();
    end
    chk("t6_ack_wins", {m0.ack, m0.err}, 2'b10);
    nerr = 0; nerr_z = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick(); s.ack = 1'b0; settle();
      nerr   += int'(m0.err);
      nerr_z += int'(m0z.err | m1z.err);
    end
    chk("t6_wd_periodic", nerr, 62);
    chk("t6_nowd_1000", nerr_z, 0);

    // Randomized traffic, including long stalls and stray resets
    do_reset();
    rand_phase(2000, 30, 20, 70, 40, 1);
    rand_phase(1500, 40, 2, 95, 3, 0);
    rand_phase(1000, 50, 10, 50, 60, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
